// File: rtl/video_pkg.sv
// video_pkg: shared timing constants and receiver state
// type for the video_if sink.
package video_pkg;

  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  localparam int CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/video_if.sv
// video_if: HS/VS/BLANK/RGB raster bundle between a
// timing generator (master) and a sink (slave).
interface video_if;

  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (
    output CLK, HS, VS, BLANK, RGB
  );

  modport slave (
    input CLK, HS, VS, BLANK, RGB
  );

endinterface

// File: rtl/video_meas.sv
// video_meas: edge strobes, saturating geometry counters
// and HS watchdog for the video receiver.
module video_meas
  import video_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WDOG  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             vs,
  input  logic             blank,
  output logic             hs_fall,
  output logic             vs_fall,
  output logic             blank_rise,
  output logic             blank_fall,
  output logic [CNT_W-1:0] meas_htotal,
  output logic [CNT_W-1:0] meas_hact,
  output logic [CNT_W-1:0] meas_vact,
  output logic             vact_ok,
  output logic             hact_bad,
  output logic             htot_chg,
  output logic             wd_expire
);

  localparam int WW = $clog2(WDOG) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] H_EXP = CNT_W'(HDISP);
  localparam logic [CNT_W-1:0] V_EXP = CNT_W'(VDISP);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG - 1);
  localparam logic [WW-1:0] WD_FULL = WW'(WDOG);

  logic             hs_q;
  logic             vs_q;
  logic             blank_q;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] vact_new;
  logic [WW-1:0]    wd_cnt;

  assign hs_fall    = hs_q & ~hs;
  assign vs_fall    = vs_q & ~vs;
  assign blank_rise = ~blank_q & blank;
  assign blank_fall = blank_q & ~blank;

  // active-line count including a blank edge landing on VS
  assign vact_new = (blank_fall && v_cnt != CMAX)
                  ? v_cnt + 1'b1 : v_cnt;

  assign vact_ok   = vact_new == V_EXP;
  assign hact_bad  = blank_fall && a_cnt != H_EXP;
  assign htot_chg  = hs_fall && h_cnt != meas_htotal;
  assign wd_expire = !hs_fall && wd_cnt == WD_LAST;

  // previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      blank_q <= blank;
    end
  end

  // line period: restart at 1 so the latch holds the full span
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      meas_htotal <= '0;
    end else if (hs_fall) begin
      h_cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
      meas_htotal <= h_cnt;
    end else if (h_cnt != CMAX) begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // active width: count BLANK-high cycles, latch at BLANK fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cnt     <= '0;
      meas_hact <= '0;
    end else if (blank_fall) begin
      a_cnt     <= '0;
      meas_hact <= a_cnt;
    end else if (blank && a_cnt != CMAX) begin
      a_cnt <= a_cnt + 1'b1;
    end
  end

  // active lines: count BLANK falls, latch at VS fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_cnt     <= '0;
      meas_vact <= '0;
    end else if (vs_fall) begin
      v_cnt     <= '0;
      meas_vact <= vact_new;
    end else begin
      v_cnt <= vact_new;
    end
  end

  // watchdog parks at WDOG so expiry fires only once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (hs_fall) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_FULL) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_rx.sv
// video_rx: video_if sink recovering a coordinate-tagged
// pixel stream and tracking lock to HDISP x VDISP.
module video_rx
  import video_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WDOG  = 4096
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  video_if.slave                   video_ifs,
  output logic                     pix_valid,
  output logic [23:0]              pix_rgb,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic                     sof,
  output logic                     eol,
  output logic                     locked,
  output logic [CNT_W-1:0]         meas_htotal,
  output logic [CNT_W-1:0]         meas_hact,
  output logic [CNT_W-1:0]         meas_vact,
  output logic                     timing_err
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [XW:0] X_LIM  = (XW+1)'(HDISP);
  localparam logic [XW:0] X_LAST = (XW+1)'(HDISP - 1);
  localparam logic [YW:0] Y_LIM  = (YW+1)'(VDISP);

  rx_state_t   state;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_blank;
  logic [23:0] s1_rgb;
  logic        hs_fall;
  logic        vs_fall;
  logic        blank_rise;
  logic        blank_fall;
  logic        vact_ok;
  logic        hact_bad;
  logic        htot_chg;
  logic        wd_expire;
  logic        hact_f;
  logic        htot_f;
  logic        frame_ok;
  logic [XW:0] x_cnt;
  logic [XW:0] x_cur;
  logic [YW:0] y_cnt;
  logic        in_act;
  logic        pix_ok;

  // stage 1: register the raw raster inputs
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      s1_rgb   <= '0;
    end else begin
      s1_hs    <= video_ifs.HS;
      s1_vs    <= video_ifs.VS;
      s1_blank <= video_ifs.BLANK;
      s1_rgb   <= video_ifs.RGB;
    end
  end

  video_meas #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .CNT_W (CNT_W),
    .WDOG  (WDOG)
  ) u_meas (
    .clk         (pixel_clk),
    .rst_n       (pixel_rst_n),
    .hs          (s1_hs),
    .vs          (s1_vs),
    .blank       (s1_blank),
    .hs_fall     (hs_fall),
    .vs_fall     (vs_fall),
    .blank_rise  (blank_rise),
    .blank_fall  (blank_fall),
    .meas_htotal (meas_htotal),
    .meas_hact   (meas_hact),
    .meas_vact   (meas_vact),
    .vact_ok     (vact_ok),
    .hact_bad    (hact_bad),
    .htot_chg    (htot_chg),
    .wd_expire   (wd_expire)
  );

  assign x_cur  = blank_rise ? '0 : x_cnt;
  assign in_act = s1_blank && x_cur < X_LIM
               && y_cnt < Y_LIM;
  assign pix_ok = in_act && state == LOCKED;

  // a line/HS event on the VS cycle is folded in first
  assign frame_ok = vact_ok && !hact_f && !hact_bad
                 && !htot_f && !htot_chg;

  // column and row counters, parked one past the last
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (s1_blank && x_cur != X_LIM)
        x_cnt <= x_cur + 1'b1;
      if (vs_fall)
        y_cnt <= '0;
      else if (blank_fall && y_cnt != Y_LIM)
        y_cnt <= y_cnt + 1'b1;
    end
  end

  // stage 2: registered pixel outputs, data held when idle
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= pix_ok;
      sof <= pix_ok && x_cur == '0 && y_cnt == '0;
      eol <= pix_ok && x_cur == X_LAST;
      if (pix_ok) begin
        pix_rgb <= s1_rgb;
        pix_x   <= x_cur[XW-1:0];
        pix_y   <= y_cnt[YW-1:0];
      end
    end
  end

  // lock FSM with per-frame error flags
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      timing_err <= 1'b0;
      hact_f     <= 1'b0;
      htot_f     <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      if (vs_fall) begin
        hact_f <= 1'b0;
        htot_f <= 1'b0;
      end else begin
        hact_f <= hact_f | hact_bad;
        htot_f <= htot_f | htot_chg;
      end
      if (wd_expire) begin
        state      <= SEARCH;
        locked     <= 1'b0;
        timing_err <= state == LOCKED;
      end else begin
        unique case (state)
          SEARCH: begin
            if (vs_fall)
              state <= SYNC;
          end
          SYNC: begin
            if (vs_fall && frame_ok) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (htot_chg || (vs_fall && !frame_ok)) begin
              state      <= SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_rx.sv
// tb_video_rx: random-pixel raster source, frame-level lock
// model and pixel scoreboard for video_rx.
module tb_video_rx;

  localparam int HD = 20;
  localparam int HF = 4;
  localparam int HP = 4;
  localparam int HB = 4;
  localparam int HT = HD + HF + HP + HB;
  localparam int VD = 10;
  localparam int VF = 2;
  localparam int VP = 2;
  localparam int VB = 2;
  localparam int VT = VD + VF + VP + VB;
  localparam int WD = 4096;
  localparam int XW = $clog2(HD);
  localparam int YW = $clog2(VD);

  localparam int M_SEARCH = 0;
  localparam int M_SYNC   = 1;
  localparam int M_LOCKED = 2;

  typedef struct {
    logic [23:0]   rgb;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid;
  logic [23:0]   pix_rgb;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;
  logic          locked;
  logic [11:0]   meas_htotal;
  logic [11:0]   meas_hact;
  logic [11:0]   meas_vact;
  logic          timing_err;

  always #5 clk = ~clk;

  video_if vif ();
  assign vif.CLK = clk;

  video_rx #(
    .HDISP (HD),
    .VDISP (VD),
    .CNT_W (12),
    .WDOG  (WD)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .video_ifs   (vif),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .sof         (sof),
    .eol         (eol),
    .locked      (locked),
    .meas_htotal (meas_htotal),
    .meas_hact   (meas_hact),
    .meas_vact   (meas_vact),
    .timing_err  (timing_err)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_state = M_SEARCH;
  bit   seg_bad = 1'b1;
  int   exp_err = 0;
  int   err_seen = 0;
  int   exp_pix = 0;
  int   pix_seen = 0;
  int   exp_sof = 0;
  int   sof_seen = 0;
  int   exp_eol = 0;
  int   eol_seen = 0;
  bit   err_prev = 1'b0;
  exp_t sb[$];
  exp_t got;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(logic hs, logic vs, logic bl,
                      logic [23:0] rgb, logic rst);
    vif.HS    = hs;
    vif.VS    = vs;
    vif.BLANK = bl;
    vif.RGB   = rgb;
    rst_n     = ~rst;
    @(posedge clk);
    #1;
  endtask

  // frame-level lock rules evaluated at each VS fall
  function automatic void vs_event();
    if (m_state == M_SEARCH) begin
      m_state = M_SYNC;
    end else if (m_state == M_SYNC) begin
      if (!seg_bad) m_state = M_LOCKED;
    end else if (seg_bad) begin
      m_state = M_SEARCH;
      exp_err++;
    end
    seg_bad = 1'b0;
  endfunction

  task automatic frame(int wide, int rst_line, bit spot);
    logic [23:0] rgb;
    bit          bl;
    bit          hs;
    bit          vs;
    bit          rst;
    int          alen;
    exp_t        e;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        alen = (l == wide) ? HD + 1 : HD;
        bl   = (l < VD) && (c < alen);
        hs   = !(c >= HD + HF && c < HD + HF + HP);
        vs   = !(l >= VD + VF && l < VD + VF + VP);
        rst  = (l == rst_line) && (c == 0);
        rgb  = 24'($urandom);
        if (spot && l == 7 && c == 5) rgb = 24'h123456;
        if (rst) begin
          m_state = M_SEARCH;
          seg_bad = 1'b1;
          sb.delete();
        end
        if (l == wide && c == 0) seg_bad = 1'b1;
        if (l == VD + VF && c == 0) vs_event();
        if (bl && m_state == M_LOCKED && c < HD) begin
          e.rgb = rgb;
          e.x   = XW'(c);
          e.y   = YW'(l);
          e.sof = (c == 0) && (l == 0);
          e.eol = (c == HD - 1);
          sb.push_back(e);
          exp_pix++;
          if (e.sof) exp_sof++;
          if (e.eol) exp_eol++;
        end
        tick(hs, vs, bl, rgb, rst);
        if (rst) begin
          check("rst_pix", {pix_valid, pix_rgb, pix_x,
                pix_y, sof, eol, locked, timing_err}, 0);
          check("rst_meas", {meas_htotal, meas_hact,
                meas_vact}, 0);
        end
        if (l == wide && c == HT - 1)
          check("wide_hact", meas_hact, HD + 1);
      end
    end
    check("frame_locked", locked, m_state == M_LOCKED);
    check("frame_errs", err_seen, exp_err);
  endtask

  task automatic stall(int n);
    if (m_state == M_LOCKED) exp_err++;
    m_state = M_SEARCH;
    seg_bad = 1'b1;
    repeat (n) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    check("wdog_locked", locked, 0);
    check("wdog_errs", err_seen, exp_err);
  endtask

  // monitor: pop and compare whenever a pixel is presented
  always @(negedge clk) begin
    if (pix_valid) begin
      pix_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra: got x=%0d y=%0d none expected",
                 pix_x, pix_y);
      end else begin
        got = sb.pop_front();
        if ({pix_rgb, pix_x, pix_y, sof, eol} !==
            {got.rgb, got.x, got.y, got.sof, got.eol}) begin
          errors++;
          $display("FAIL pixel: got %h x%0d y%0d s%0b e%0b expected %h x%0d y%0d s%0b e%0b",
                   pix_rgb, pix_x, pix_y, sof, eol,
                   got.rgb, got.x, got.y, got.sof, got.eol);
        end
      end
    end
    if (sof) sof_seen++;
    if (eol) eol_seen++;
    if (timing_err) begin
      err_seen++;
      if (err_prev) begin
        checks++;
        errors++;
        $display("FAIL err_width: got 2+ cycles expected 1");
      end
    end
    err_prev = timing_err;
  end

  initial begin
    repeat (3) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    check("reset_pix", {pix_valid, pix_rgb, pix_x, pix_y,
          sof, eol, locked, timing_err}, 0);
    check("reset_meas", {meas_htotal, meas_hact,
          meas_vact}, 0);
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b0);
    check("meas_htotal", meas_htotal, HT);
    check("meas_hact", meas_hact, HD);
    check("meas_vact", meas_vact, VD);
    frame(-1, -1, 1'b1);
    frame(-1, -1, 1'b0);
    frame(int'($urandom_range(VD - 1, 0)), -1, 1'b0);
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b0);
    stall(int'($urandom_range(4300, 4100)));
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b0);
    frame(-1, 3, 1'b0);
    frame(-1, -1, 1'b0);
    frame(-1, -1, 1'b1);
    repeat (10) tick(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    check("sb_empty", sb.size(), 0);
    check("pix_count", pix_seen, exp_pix);
    check("sof_count", sof_seen, exp_sof);
    check("eol_count", eol_seen, exp_eol);
    check("err_count", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
